// File: rtl/gfx_pkg.sv
// Shared definitions for the pixel-pipeline Wishbone arbiters: requester
// indices, arbiter state encoding and the default requester count.
package gfx_pkg;

   localparam int NUM_REQ_DEFAULT = 3;

   localparam int REQ_ZBUF  = 0;
   localparam int REQ_TEX   = 1;
   localparam int REQ_BLEND = 2;

   typedef enum logic {
      IDLE = 1'b0,
      READ = 1'b1
   } arb_state_e;

endpackage

// File: rtl/gfx_rr_pick.sv
// Combinational round-robin priority encoder: the first requester at or after
// ptr_i (wrapping) wins. Shared by the read- and write-side arbiters.
module gfx_rr_pick #(
   parameter  int NUM_REQ = 3,
   localparam int PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic [NUM_REQ-1:0] req_i,
   input  logic [PW-1:0]      ptr_i,
   output logic [PW-1:0]      win_o,
   output logic               valid_o
);

   logic [2*NUM_REQ-1:0] dbl;
   logic [NUM_REQ-1:0]   rot;
   logic [PW:0]          off;
   logic [PW:0]          sum;

   always_comb begin
      dbl     = {req_i, req_i} >> ptr_i;
      rot     = dbl[NUM_REQ-1:0];
      off     = '0;
      valid_o = 1'b0;
      // Scan downwards so the smallest offset from the pointer is kept last.
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         if (rot[k]) begin
            off     = (PW+1)'(k);
            valid_o = 1'b1;
         end
      end
      sum = {1'b0, ptr_i} + off;
      if (sum >= (PW+1)'(NUM_REQ)) begin
         sum = sum - (PW+1)'(NUM_REQ);
      end
      win_o = sum[PW-1:0];
   end

endmodule

// File: rtl/gfx_wbm_read_arbiter.sv
// Round-robin arbiter sharing one Wishbone read master among the z-buffer,
// texture and blender readers; one outstanding read, grant held until ack.
module gfx_wbm_read_arbiter
   import gfx_pkg::*;
#(
   parameter  int NUM_REQ = NUM_REQ_DEFAULT,
   localparam int PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic [NUM_REQ-1:0]    req_i,
   input  logic [NUM_REQ*30-1:0] addr_i,
   input  logic [NUM_REQ*4-1:0]  sel_i,
   output logic [NUM_REQ-1:0]    ack_o,
   output logic [31:0]           data_o,
   output logic [NUM_REQ-1:0]    busy_o,
   output logic                  m_request_o,
   output logic [29:0]           m_addr_o,
   output logic [3:0]            m_sel_o,
   input  logic                  m_ack_i,
   input  logic [31:0]           m_data_i,
   input  logic                  m_busy_i
);

   arb_state_e         state_q, state_d;
   logic [PW-1:0]      grant_q, grant_d;
   logic [PW-1:0]      ptr_q, ptr_d;
   logic [29:0]        addr_q, addr_d;
   logic [3:0]         sel_q, sel_d;
   logic [NUM_REQ-1:0] ack_q, ack_d;
   logic [31:0]        data_q, data_d;

   logic [PW-1:0]      win;
   logic               win_valid;
   logic [29:0]        win_addr;
   logic [3:0]         win_sel;

   gfx_rr_pick #(.NUM_REQ(NUM_REQ)) u_pick (
      .req_i   (req_i),
      .ptr_i   (ptr_q),
      .win_o   (win),
      .valid_o (win_valid)
   );

   always_comb begin
      win_addr = '0;
      win_sel  = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (win == PW'(i)) begin
            win_addr = addr_i[30*i +: 30];
            win_sel  = sel_i[4*i +: 4];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      addr_d  = addr_q;
      sel_d   = sel_q;
      ack_d   = '0;
      data_d  = data_q;
      case (state_q)
         IDLE: begin
            // A stray m_ack_i here belongs to no transaction and is dropped.
            if (win_valid && !m_busy_i) begin
               grant_d = win;
               addr_d  = win_addr;
               sel_d   = win_sel;
               state_d = READ;
            end
         end
         READ: begin
            if (m_ack_i) begin
               for (int i = 0; i < NUM_REQ; i++) begin
                  ack_d[i] = (grant_q == PW'(i));
               end
               data_d  = m_data_i;
               ptr_d   = (grant_q == PW'(NUM_REQ - 1)) ? '0 : grant_q + PW'(1);
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         grant_q <= '0;
         ptr_q   <= '0;
         addr_q  <= '0;
         sel_q   <= 4'hF;
         ack_q   <= '0;
         data_q  <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
         addr_q  <= addr_d;
         sel_q   <= sel_d;
         ack_q   <= ack_d;
         data_q  <= data_d;
      end
   end

   assign m_request_o = (state_q == READ);
   assign m_addr_o    = addr_q;
   assign m_sel_o     = sel_q;
   assign ack_o       = ack_q;
   assign data_o      = data_q;
   assign busy_o      = {NUM_REQ{(state_q != IDLE) | m_busy_i}};

endmodule
